// File: rtl/lzx_seg7_pkg.sv
// Shared segment codes and the nibble-to-segment encoder for the LZX 7-segment drivers.
// Segment bit order is {g,f,e,d,c,b,a}, active-high form.
package lzx_seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ALL   = 7'h7F;

  // Codes 10-15 blank unless hex display is enabled, matching the 4511 rule.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble, input logic hex_en);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_en ? SEG_A : SEG_BLANK;
      4'hB: seg = hex_en ? SEG_B : SEG_BLANK;
      4'hC: seg = hex_en ? SEG_C : SEG_BLANK;
      4'hD: seg = hex_en ? SEG_D : SEG_BLANK;
      4'hE: seg = hex_en ? SEG_E : SEG_BLANK;
      default: seg = hex_en ? SEG_F : SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/lzx_seg7_decode.sv
// Combinational segment decoder with lamp-test, blanking-input and external blank priority.
// Output is active-high; polarity is applied by the caller at its output register.
module lzx_seg7_decode
  import lzx_seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] nibble_i,
  input  logic       lt_n_i,
  input  logic       bi_n_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Lamp test beats blanking input, which beats leading-zero blank.
  always_comb begin
    if (!lt_n_i)      seg_o = SEG_ALL;
    else if (!bi_n_i) seg_o = SEG_BLANK;
    else if (blank_i) seg_o = SEG_BLANK;
    else              seg_o = seg7_encode(nibble_i, HEX_EN);
  end

endmodule

// File: rtl/lzx_seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver: data latch, slot prescaler, digit index,
// leading-zero blanking and registered segment/digit outputs with one dead clk per slot.
module lzx_seg7_scan_driver
  import lzx_seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int HEX_EN         = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  BI_n,
  input  logic                  LT_n,
  input  logic                  LE,
  input  logic                  lzb_en,
  input  logic [4*DIGITS-1:0]   D,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0]        SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [DIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         index_q, index_d;
  logic [4*DIGITS-1:0]   data_q, data_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  presc_last;
  logic                  index_last;
  logic [3:0]            nibble_sel;
  logic                  lz_blank;
  logic                  zero_above;
  logic [6:0]            seg_raw;
  logic [DIGITS-1:0]     dig_raw;

  assign presc_last = (presc_q == PW'(SCAN_DIV - 1));
  assign index_last = (index_q == IW'(DIGITS - 1));
  assign presc_d    = presc_last ? '0 : presc_q + PW'(1);
  assign index_d    = !presc_last ? index_q : (index_last ? '0 : index_q + IW'(1));
  assign data_d     = LE ? data_q : D;

  // Outputs are computed from next-state counters so the registered values line up
  // with the slot they describe: dead time lands on the clk where the prescaler reads 0.
  // NOTE: every signal driven in always_comb gets a default first, otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    nibble_sel = 4'h0;
    lz_blank   = 1'b0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (data_q[4*k +: 4] == 4'h0);
      if (index_d == IW'(k)) begin
        nibble_sel = data_q[4*k +: 4];
        lz_blank   = zero_above && (k != 0);
      end
    end
  end

  lzx_seg7_decode #(
    .HEX_EN (HEX_EN != 0)
  ) u_decode (
    .nibble_i (nibble_sel),
    .lt_n_i   (LT_n),
    .bi_n_i   (BI_n),
    .blank_i  (lzb_en & lz_blank),
    .seg_o    (seg_raw)
  );

  assign dig_raw      = (presc_d == '0) ? '0 : (DIGITS'(1) << index_d);
  assign seg_d        = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  assign dig_sel_d    = (DIG_ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;
  assign frame_tick_d = (presc_d == PW'(SCAN_DIV - 1)) && (index_d == IW'(DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      index_q      <= '0;
      data_q       <= '0;
      seg_q        <= SEG_IDLE;
      dig_sel_q    <= DIG_IDLE;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      index_q      <= index_d;
      data_q       <= data_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign frame_tick = frame_tick_q;

endmodule
